// File: rtl/data_mem_sequencer.sv
// data_mem_sequencer: sequences core load/store accesses onto a req/ready data memory
// with lane steering, load extension, misalignment and timeout reporting.
module data_mem_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [2:0]            modeBU,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misalign_err,
  output logic                  timeout_err,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic [3:0]            dm_be,
  output logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic                  dm_ready,
  input  logic [DATA_WIDTH-1:0] dm_rdata
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d, tout_q, tout_d;
  logic [2:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, ext;
  logic [7:0]            lbyte;
  logic [15:0]           lhalf;
  logic                  illegal, in_req;
  assign illegal = (modeBU == 3'd0) || (modeBU == 3'd6) || (modeBU == 3'd7) ||
                   (mem_we && modeBU[2]) ||
                   ((modeBU == 3'd2 || modeBU == 3'd4) && addr[0]) ||
                   (modeBU == 3'd1 && addr[1:0] != 2'b00);
  assign lbyte = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lhalf = dm_rdata[{addr_q[1], 4'b0000} +: 16];
  assign ext = mode_q == 3'd3 ? {{(DATA_WIDTH-8){lbyte[7]}}, lbyte} :
               mode_q == 3'd5 ? {{(DATA_WIDTH-8){1'b0}}, lbyte} :
               mode_q == 3'd2 ? {{(DATA_WIDTH-16){lhalf[15]}}, lhalf} :
               mode_q == 3'd4 ? {{(DATA_WIDTH-16){1'b0}}, lhalf} : dm_rdata;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tout_d  = tout_q;
    case (state_q)
      IDLE: begin
        we_d    = mem_we;
        mode_d  = modeBU;
        addr_d  = addr;
        wdata_d = wdata;
        cnt_d   = '0;
        tout_d  = 1'b0;
        rdata_d = '0;
        state_d = mem_en ? (illegal ? ERR : REQ) : IDLE;
      end
      REQ: begin
        // a ready in the final wait cycle still counts as success
        if (dm_ready) begin
          state_d = DONE;
          rdata_d = we_q ? '0 : ext;
        end else if (cnt_q == LAST) begin
          state_d = DONE;
          tout_d  = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tout_q  <= tout_d;
    end
  end
  assign in_req       = state_q == REQ;
  // stall is gated by rst_n so it drops with reset even while mem_en is held
  assign stall        = rst_n && (state_q == IDLE ? mem_en : in_req);
  assign done         = state_q == DONE || state_q == ERR;
  assign misalign_err = state_q == ERR;
  assign timeout_err  = state_q == DONE && tout_q;
  assign rdata        = state_q == DONE ? rdata_q : '0;
  assign dm_req       = in_req;
  assign dm_we        = in_req && we_q;
  assign dm_addr      = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dm_be        = !in_req ? 4'b0000 : !we_q ? 4'b1111 :
                        (mode_q == 3'd3) ? 4'b0001 << addr_q[1:0] :
                        (mode_q == 3'd2) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dm_wdata     = !in_req ? '0 :
                        (mode_q == 3'd3) ? {4{wdata_q[7:0]}} :
                        (mode_q == 3'd2) ? {2{wdata_q[15:0]}} : wdata_q;
endmodule

// File: tb/tb_data_mem_sequencer.sv
// tb_data_mem_sequencer: directed load/store/error/timeout/reset checks with a
// behavioural memory that raises dm_ready after a chosen number of request cycles.
module tb_data_mem_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, mem_en, mem_we, dm_ready;
  logic [2:0]  modeBU;
  logic [31:0] addr, wdata, dm_rdata;
  logic        stall, done, misalign_err, timeout_err, dm_req, dm_we;
  logic [31:0] rdata, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  int          checks = 0;
  int          failures = 0;
  int          lat, reqs, stalls;
  logic [3:0]  be_s;
  logic [31:0] wd_s, ad_s;
  logic        we_s;

  always #5 clk = ~clk;

  data_mem_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_we(mem_we), .modeBU(modeBU),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign_err(misalign_err), .timeout_err(timeout_err), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Runs one access from IDLE; returns with time inside the done cycle (or after the bound).
  task automatic xact(input logic we, input logic [2:0] mode, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int waits);
    mem_en = 1'b1; mem_we = we; modeBU = mode; addr = a; wdata = wd;
    dm_rdata = rd; dm_ready = 1'b0;
    lat = -1; reqs = 0; stalls = 0;
    be_s = 'x; wd_s = 'x; ad_s = 'x; we_s = 1'bx;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done) begin
        lat = c;
        break;
      end
      if (stall) stalls++;
      if (dm_req) begin
        reqs++;
        dm_ready = reqs > waits;
        if (dm_ready) begin
          be_s = dm_be; wd_s = dm_wdata; ad_s = dm_addr; we_s = dm_we;
        end
      end
      @(posedge clk);
      #1;
      dm_ready = 1'b0;
    end
  endtask

  task automatic finish_xact;
    mem_en = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; mem_en = 1'b0; mem_we = 1'b0; modeBU = 3'd1;
    addr = '0; wdata = '0; dm_ready = 1'b0; dm_rdata = '0;
    #12;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dm_req", {31'b0, dm_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_dm_be", {28'b0, dm_be}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // dm_ready without a request must not produce anything
    dm_ready = 1'b1;
    cyc();
    dm_ready = 1'b0;
    #1;
    chk("idle_ready_done", {31'b0, done}, 32'd0);
    chk("idle_ready_stall", {31'b0, stall}, 32'd0);
    cyc();

    xact(1'b0, 3'd1, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    chk("lw_lat", lat, 32'd5);
    chk("lw_stalls", stalls, 32'd5);
    chk("lw_reqs", reqs, 32'd4);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_be", {28'b0, be_s}, 32'hF);
    chk("lw_addr", ad_s, 32'h100);
    chk("lw_done_stall", {31'b0, stall}, 32'd0);
    chk("lw_terr", {31'b0, timeout_err}, 32'd0);
    finish_xact();
    chk("lw_after_done", {31'b0, done}, 32'd0);

    xact(1'b0, 3'd3, 32'h103, 32'h0, 32'h80FF1234, 0);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    finish_xact();
    xact(1'b0, 3'd5, 32'h103, 32'h0, 32'h80FF1234, 0);
    chk("lbu_rdata", rdata, 32'h00000080);
    finish_xact();
    xact(1'b0, 3'd2, 32'h102, 32'h0, 32'h80011234, 1);
    chk("lh_rdata", rdata, 32'hFFFF8001);
    finish_xact();
    xact(1'b0, 3'd4, 32'h200, 32'h0, 32'h1234F00D, 0);
    chk("lhu_rdata", rdata, 32'h0000F00D);
    finish_xact();

    xact(1'b1, 3'd2, 32'h102, 32'h0000ABCD, 32'h0, 0);
    chk("sh_lat", lat, 32'd2);
    chk("sh_be", {28'b0, be_s}, 32'hC);
    chk("sh_wdata", wd_s, 32'hABCDABCD);
    chk("sh_we", {31'b0, we_s}, 32'd1);
    chk("sh_addr", ad_s, 32'h100);
    finish_xact();
    xact(1'b1, 3'd3, 32'h101, 32'h12345678, 32'h0, 0);
    chk("sb_be", {28'b0, be_s}, 32'h2);
    chk("sb_wdata", wd_s, 32'h78787878);
    finish_xact();
    xact(1'b1, 3'd1, 32'h204, 32'hCAFEF00D, 32'h0, 2);
    chk("sw_be", {28'b0, be_s}, 32'hF);
    chk("sw_wdata", wd_s, 32'hCAFEF00D);
    chk("sw_addr", ad_s, 32'h204);
    finish_xact();

    xact(1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0);
    chk("lw_mis_lat", lat, 32'd1);
    chk("lw_mis_err", {31'b0, misalign_err}, 32'd1);
    chk("lw_mis_reqs", reqs, 32'd0);
    chk("lw_mis_stall", {31'b0, stall}, 32'd0);
    finish_xact();
    xact(1'b1, 3'd5, 32'h100, 32'h0, 32'h0, 0);
    chk("sw_mode5_err", {31'b0, misalign_err}, 32'd1);
    chk("sw_mode5_reqs", reqs, 32'd0);
    finish_xact();
    xact(1'b0, 3'd0, 32'h100, 32'h0, 32'h0, 0);
    chk("mode0_err", {31'b0, misalign_err}, 32'd1);
    finish_xact();

    xact(1'b0, 3'd1, 32'h300, 32'h0, 32'h55AA55AA, 100);
    chk("to_reqs", reqs, 32'd15);
    chk("to_lat", lat, 32'd16);
    chk("to_err", {31'b0, timeout_err}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    chk("to_dm_req", {31'b0, dm_req}, 32'd0);
    finish_xact();
    xact(1'b0, 3'd1, 32'h300, 32'h0, 32'h55AA55AA, 14);
    chk("edge_reqs", reqs, 32'd15);
    chk("edge_terr", {31'b0, timeout_err}, 32'd0);
    chk("edge_rdata", rdata, 32'h55AA55AA);
    finish_xact();

    mem_en = 1'b1; mem_we = 1'b0; modeBU = 3'd1; addr = 32'h400; dm_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_mid_req_before", {31'b0, dm_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dm_req", {31'b0, dm_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    mem_en = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", {31'b0, dm_req}, 32'd0);
    xact(1'b0, 3'd1, 32'h400, 32'h0, 32'h13579BDF, 0);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_rdata", rdata, 32'h13579BDF);
    finish_xact();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
